// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - buffers one ROWS x COLS frame from a serial stream
// and replays it row-major or transposed.
module matrix_stream_loader #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              transpose,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_err,
  output logic              busy
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {ST_LOAD, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [IW-1:0]     src_idx;
  logic              tr_q, tr_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic [DATA_W-1:0] buf_q [N];

  // Transposed read walks down each stored column in turn.
  always_comb begin
    int k;
    k = int'(rd_idx_q);
    src_idx = tr_q ? IW'((k % ROWS) * COLS + (k / ROWS)) : rd_idx_q;
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    tr_d     = tr_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == '0) tr_d = transpose;
          if (wr_idx_q == LAST) begin
            wr_idx_d = '0;
            state_d  = ST_DRAIN;
            err_d    = ~s_last;
          end else if (s_last) begin
            wr_idx_d = '0;
            err_d    = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d = '0;
            state_d  = ST_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (flush) begin
      state_d  = ST_LOAD;
      wr_idx_d = '0;
      rd_idx_d = '0;
      err_d    = 1'b0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      tr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      tr_q     <= tr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx_q] <= s_data;
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign m_valid   = (state_q == ST_DRAIN);
  assign busy      = m_valid;
  assign m_last    = m_valid && (rd_idx_q == LAST);
  assign m_data    = m_valid ? buf_q[src_idx] : buf_q[0];
  assign frame_err = err_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb/tb_matrix_stream_loader.sv - randomized directed bench for matrix_stream_loader
// against a matrix-level reference model.
module tb_matrix_stream_loader;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n, flush, transpose, s_valid, s_last, m_ready;
  logic [15:0] s_data;
  logic        s_ready, m_valid, m_last, frame_err, busy;
  logic [15:0] m_data;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] in_arr [N];
  logic [15:0] exp_q [$];

  matrix_stream_loader #(.DATA_W(16), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .transpose(transpose),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) in_arr[i] = 16'(i * 16'h1111);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) in_arr[i] = 16'($urandom);
  endtask

  // Expected output: the stored matrix read by rows, or its columns read top to bottom.
  task automatic build_expected(input bit tr);
    exp_q.delete();
    if (!tr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) exp_q.push_back(in_arr[r*COLS + c]);
    end else begin
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++) exp_q.push_back(in_arr[r*COLS + c]);
    end
  endtask

  task automatic load(input int n, input int last_pos, input bit tr, input bit gaps);
    bit exp_err;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          s_valid = 1'b0;
          step();
          check("gap_m_valid", m_valid, 0);
        end
      end
      check("load_s_ready", s_ready, 1);
      s_valid   = 1'b1;
      s_data    = in_arr[i];
      s_last    = (i == last_pos);
      transpose = (i == 0) ? tr : 1'($urandom_range(0, 1));
      step();
      exp_err = ((i == last_pos) && (i < N-1)) || ((i == N-1) && (last_pos != N-1));
      check("frame_err", frame_err, exp_err);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input bit tr, input bit bp, input int stop_after);
    int          k = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [15:0] hd;
    logic        hl;
    build_expected(tr);
    while (k < N && cyc < 100) begin
      cyc++;
      check("drain_m_valid", m_valid, 1);
      check("drain_busy", busy, 1);
      check("drain_s_ready", s_ready, 0);
      if (cyc > 1) check("drain_frame_err", frame_err, 0);
      if (stalled) begin
        check("stall_m_data", m_data, hd);
        check("stall_m_last", m_last, hl);
      end
      if (k == stop_after) begin
        m_ready = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        check("flush_m_valid", m_valid, 0);
        check("flush_s_ready", s_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_m_data", m_data, in_arr[0]);
        return;
      end
      m_ready = bp ? ((cyc % 2) == 1) : 1'b1;
      if (m_ready) begin
        check("m_data", m_data, exp_q[k]);
        check("m_last", m_last, (k == N-1));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        hd = m_data;
        hl = m_last;
      end
      step();
    end
    m_ready = 1'b0;
    check("drain_count", k, N);
    check("post_m_valid", m_valid, 0);
    check("post_s_ready", s_ready, 1);
    check("post_busy", busy, 0);
    check("post_m_last", m_last, 0);
    check("post_m_data", m_data, in_arr[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; transpose = 1'b0; s_valid = 1'b0;
    s_last = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    fill_pattern();
    load(N, N-1, 0, 0);
    drain(0, 0, -1);

    load(N, N-1, 1, 0);
    drain(1, 0, -1);

    fill_random();
    load(N, N-1, 0, 1);
    drain(0, 1, -1);

    fill_pattern();
    load(5, 4, 0, 0);
    check("early_m_valid", m_valid, 0);
    step();
    check("early_err_cleared", frame_err, 0);
    check("early_still_idle", m_valid, 0);
    load(N, N-1, 0, 0);
    drain(0, 0, -1);

    load(N, -1, 1, 0);
    drain(1, 0, -1);

    load(N, N-1, 0, 0);
    drain(0, 0, 8);
    load(6, -1, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fill_random();
    load(N, N-1, 1, 1);
    drain(1, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
